// File: rtl/memory_access_stage_pkg.sv
// Shared widths, state encoding and the memory-op decode for the memory access stage.
package memory_access_stage_pkg;

  // Default widths of the data-memory port and the write-back path.
  localparam int ADDR  = 16;
  localparam int W_OPR = 32;
  localparam int W_RD  = 5;

  // Access sequencing: IDLE accepts work, REQ has a request outstanding,
  // DONE holds a completed access while write-back is stalled.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } mas_state_e;

  // An instruction needs the data-memory port when it is valid and is a load or store.
  function automatic logic is_mem_op(input logic v, input logic ld, input logic st);
    return v & (ld | st);
  endfunction

endpackage

// File: rtl/memory_access_stage_mem_req_fsm.sv
// Data-memory request sequencer: captures an accepted load/store, drives the
// req/ack handshake, and reports a one-cycle done pulse with the completed
// write-back data when the access can be handed to the output register.
module memory_access_stage_mem_req_fsm #(
  parameter int ADDR  = memory_access_stage_pkg::ADDR,
  parameter int W_OPR = memory_access_stage_pkg::W_OPR,
  parameter int W_RD  = memory_access_stage_pkg::W_RD
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             v_i,
  input  logic             ld_i,
  input  logic             st_i,
  input  logic [ADDR-1:0]  addr_i,
  input  logic [W_OPR-1:0] st_data_i,
  input  logic [W_RD-1:0]  wb_r_i,
  input  logic             stall_i,
  input  logic             mem_ack_i,
  input  logic [W_OPR-1:0] mem_rdata_i,
  output logic             idle,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [ADDR-1:0]  mem_addr_o,
  output logic [W_OPR-1:0] mem_wdata_o,
  output logic             done,
  output logic [W_OPR-1:0] done_result,
  output logic [W_RD-1:0]  done_wb_r,
  output logic             done_wb
);

  import memory_access_stage_pkg::*;

  mas_state_e       state_reg;
  mas_state_e       state_next;
  logic             start;
  logic             ack_stalled;

  logic [ADDR-1:0]  addr_reg;
  logic [W_OPR-1:0] wdata_reg;
  logic             we_reg;
  logic             is_load_reg;
  logic [W_RD-1:0]  wb_r_reg;
  logic [W_OPR-1:0] hold_reg;

  // A memory op is taken only from IDLE and only when write-back is not stalled.
  assign start       = (state_reg == IDLE) & ~stall_i & is_mem_op(v_i, ld_i, st_i);
  assign ack_stalled = (state_reg == REQ) & mem_ack_i & stall_i;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state, done pulse and the completed write-back value.
  always_comb begin
    state_next  = state_reg;
    done        = 1'b0;
    done_result = '0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = REQ;
        end
      end
      REQ: begin
        if (mem_ack_i) begin
          if (stall_i) begin
            state_next = DONE;
          end else begin
            state_next  = IDLE;
            done        = 1'b1;
            done_result = is_load_reg ? mem_rdata_i : '0;
          end
        end
      end
      DONE: begin
        if (!stall_i) begin
          state_next  = IDLE;
          done        = 1'b1;
          done_result = is_load_reg ? hold_reg : '0;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Request registers: keep address/data/kind stable for the whole access.
  // A store wins when both ld_i and st_i are set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_reg    <= '0;
      wdata_reg   <= '0;
      we_reg      <= 1'b0;
      is_load_reg <= 1'b0;
      wb_r_reg    <= '0;
    end else if (start) begin
      addr_reg    <= addr_i;
      wdata_reg   <= st_data_i;
      we_reg      <= st_i;
      is_load_reg <= ~st_i;
      wb_r_reg    <= wb_r_i;
    end
  end

  // Hold register: the read data is only valid during the ack pulse, so keep it
  // when write-back cannot take it yet.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_reg <= '0;
    end else if (ack_stalled) begin
      hold_reg <= mem_rdata_i;
    end
  end

  assign idle        = (state_reg == IDLE);
  assign mem_req_o   = (state_reg == REQ);
  assign mem_we_o    = we_reg;
  assign mem_addr_o  = addr_reg;
  assign mem_wdata_o = wdata_reg;
  assign done_wb_r   = wb_r_reg;
  assign done_wb     = is_load_reg;

endmodule

// File: rtl/memory_access_stage.sv
// Memory access pipeline stage: passes ALU results straight to write-back with
// one cycle of latency, runs loads/stores through the data-memory handshake, and
// back-pressures execute while an access is in flight.
module memory_access_stage #(
  parameter int ADDR  = memory_access_stage_pkg::ADDR,
  parameter int W_OPR = memory_access_stage_pkg::W_OPR,
  parameter int W_RD  = memory_access_stage_pkg::W_RD
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             v_i,
  input  logic             ld_i,
  input  logic             st_i,
  input  logic [ADDR-1:0]  addr_i,
  input  logic [W_OPR-1:0] st_data_i,
  input  logic [W_OPR-1:0] result_i,
  input  logic [W_RD-1:0]  wb_r_i,
  input  logic             wb_i,
  input  logic             stall_i,
  output logic             stall_o,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [ADDR-1:0]  mem_addr_o,
  output logic [W_OPR-1:0] mem_wdata_o,
  input  logic             mem_ack_i,
  input  logic [W_OPR-1:0] mem_rdata_i,
  output logic             v_o,
  output logic [W_OPR-1:0] result_o,
  output logic [W_RD-1:0]  wb_r_o,
  output logic             wb_o
);

  import memory_access_stage_pkg::*;

  logic             idle;
  logic             done;
  logic [W_OPR-1:0] done_result;
  logic [W_RD-1:0]  done_wb_r;
  logic             done_wb;
  logic             alu_accept;

  logic             v_reg;
  logic             v_next;
  logic [W_OPR-1:0] result_reg;
  logic [W_OPR-1:0] result_next;
  logic [W_RD-1:0]  wb_r_reg;
  logic [W_RD-1:0]  wb_r_next;
  logic             wb_reg;
  logic             wb_next;

  memory_access_stage_mem_req_fsm #(
    .ADDR  (ADDR),
    .W_OPR (W_OPR),
    .W_RD  (W_RD)
  ) u_mem_req_fsm (
    .clk         (clk),
    .reset       (reset),
    .v_i         (v_i),
    .ld_i        (ld_i),
    .st_i        (st_i),
    .addr_i      (addr_i),
    .st_data_i   (st_data_i),
    .wb_r_i      (wb_r_i),
    .stall_i     (stall_i),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i),
    .idle        (idle),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .done        (done),
    .done_result (done_result),
    .done_wb_r   (done_wb_r),
    .done_wb     (done_wb)
  );

  // Execute must hold its instruction while downstream stalls or an access is busy.
  assign stall_o    = stall_i | ~idle;
  assign alu_accept = idle & v_i & ~is_mem_op(v_i, ld_i, st_i);

  // Output register next value: completed access, ALU pass-through, or bubble;
  // everything holds while write-back is stalled.
  always_comb begin
    v_next      = v_reg;
    result_next = result_reg;
    wb_r_next   = wb_r_reg;
    wb_next     = wb_reg;
    if (!stall_i) begin
      if (done) begin
        v_next      = 1'b1;
        result_next = done_result;
        wb_r_next   = done_wb_r;
        wb_next     = done_wb;
      end else if (alu_accept) begin
        v_next      = 1'b1;
        result_next = result_i;
        wb_r_next   = wb_r_i;
        wb_next     = wb_i;
      end else begin
        v_next  = 1'b0;
        wb_next = 1'b0;
      end
    end
  end

  // Output register to write-back.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_reg      <= 1'b0;
      result_reg <= '0;
      wb_r_reg   <= '0;
      wb_reg     <= 1'b0;
    end else begin
      v_reg      <= v_next;
      result_reg <= result_next;
      wb_r_reg   <= wb_r_next;
      wb_reg     <= wb_next;
    end
  end

  assign v_o      = v_reg;
  assign result_o = result_reg;
  assign wb_r_o   = wb_r_reg;
  assign wb_o     = wb_reg;

endmodule

// File: tb/tb_memory_access_stage.sv
// Self-checking bench for memory_access_stage: a vector table drives ALU ops,
// loads and stores; expected write-back records go into a scoreboard queue and
// are popped whenever the output register loads a valid result.
module tb_memory_access_stage;

  localparam int K_ALU  = 0;
  localparam int K_LD   = 1;
  localparam int K_ST   = 2;
  localparam int K_LDST = 3;

  typedef struct {
    int          kind;
    logic [15:0] addr;
    logic [31:0] data;
    logic [31:0] rdata;
    logic [4:0]  wb_r;
    logic        wb;
    int          ack_wait;
    int          stall_cycles;
    logic [31:0] exp_result;
    logic [4:0]  exp_wb_r;
    logic        exp_wb;
  } vec_t;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  wb_r;
    logic        wb;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        v_i = 1'b0;
  logic        ld_i = 1'b0;
  logic        st_i = 1'b0;
  logic [15:0] addr_i = '0;
  logic [31:0] st_data_i = '0;
  logic [31:0] result_i = '0;
  logic [4:0]  wb_r_i = '0;
  logic        wb_i = 1'b0;
  logic        stall_i = 1'b0;
  logic        stall_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [15:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        v_o;
  logic [31:0] result_o;
  logic [4:0]  wb_r_o;
  logic        wb_o;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];
  vec_t vecs[8];

  memory_access_stage dut (
    .clk         (clk),
    .reset       (reset),
    .v_i         (v_i),
    .ld_i        (ld_i),
    .st_i        (st_i),
    .addr_i      (addr_i),
    .st_data_i   (st_data_i),
    .result_i    (result_i),
    .wb_r_i      (wb_r_i),
    .wb_i        (wb_i),
    .stall_i     (stall_i),
    .stall_o     (stall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i),
    .v_o         (v_o),
    .result_o    (result_o),
    .wb_r_o      (wb_r_o),
    .wb_o        (wb_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Output monitor: a valid result loaded on an unstalled, non-reset edge is a new
  // write-back record and must match the head of the scoreboard.
  always @(posedge clk) begin : monitor
    logic fresh;
    exp_t e;
    fresh = !stall_i && !reset;
    #1;
    if (fresh && v_o) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_output: got result %h wb_r %0d with empty scoreboard", result_o, wb_r_o);
      end else begin
        e = sb.pop_front();
        chk("wb_result_o", result_o, e.result);
        chk("wb_wb_r_o", 32'(wb_r_o), 32'(e.wb_r));
        chk("wb_wb_o", 32'(wb_o), 32'(e.wb));
      end
    end
  end

  // Present one table entry, serve its memory access, and return one step after
  // the output register has loaded its result.
  task automatic run_vec(input vec_t v);
    logic is_mem;
    logic is_st;
    is_mem = (v.kind != K_ALU);
    is_st  = (v.kind == K_ST) || (v.kind == K_LDST);
    chk("stall_o_before", 32'(stall_o), 32'd0);
    v_i       = 1'b1;
    ld_i      = (v.kind == K_LD) || (v.kind == K_LDST);
    st_i      = is_st;
    addr_i    = v.addr;
    st_data_i = v.data;
    result_i  = is_mem ? 32'hCAFEF00D : v.data;
    wb_r_i    = v.wb_r;
    wb_i      = v.wb;
    sb.push_back('{v.exp_result, v.exp_wb_r, v.exp_wb});
    @(posedge clk); #1;
    v_i = 1'b0; ld_i = 1'b0; st_i = 1'b0;
    addr_i = ~v.addr; st_data_i = ~v.data; wb_r_i = ~v.wb_r;
    if (is_mem) begin
      for (int i = 0; i <= v.ack_wait; i++) begin
        chk("mem_req_o_wait", 32'(mem_req_o), 32'd1);
        chk("mem_we_o", 32'(mem_we_o), 32'(is_st));
        chk("mem_addr_o", 32'(mem_addr_o), 32'(v.addr));
        if (is_st) chk("mem_wdata_o", mem_wdata_o, v.data);
        chk("stall_o_busy", 32'(stall_o), 32'd1);
        chk("v_o_wait", 32'(v_o), 32'd0);
        if (i == v.ack_wait) begin
          mem_ack_i   = 1'b1;
          mem_rdata_i = v.rdata;
          stall_i     = (v.stall_cycles > 0);
        end
        @(posedge clk); #1;
      end
      mem_ack_i   = 1'b0;
      mem_rdata_i = ~v.rdata;
      for (int j = 0; j < v.stall_cycles; j++) begin
        chk("mem_req_o_done", 32'(mem_req_o), 32'd0);
        chk("stall_o_done", 32'(stall_o), 32'd1);
        chk("v_o_done_held", 32'(v_o), 32'd0);
        if (j == v.stall_cycles - 1) stall_i = 1'b0;
        @(posedge clk); #1;
      end
    end
    chk("stall_o_after", 32'(stall_o), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    //         kind    addr      data          rdata         wb_r   wb  wait stall exp_result    exp_wb_r exp_wb
    vecs[0] = '{K_ALU,  16'h0000, 32'h00001234, 32'h0,        5'd3,  1'b1, 0, 0, 32'h00001234, 5'd3,  1'b1};
    vecs[1] = '{K_ALU,  16'h0000, 32'hFFFFFFFF, 32'h0,        5'd31, 1'b0, 0, 0, 32'hFFFFFFFF, 5'd31, 1'b0};
    vecs[2] = '{K_LD,   16'h0040, 32'h0,        32'hDEADBEEF, 5'd7,  1'b0, 0, 0, 32'hDEADBEEF, 5'd7,  1'b1};
    vecs[3] = '{K_ST,   16'h0010, 32'hA5A5A5A5, 32'h77777777, 5'd2,  1'b1, 3, 0, 32'h00000000, 5'd2,  1'b0};
    vecs[4] = '{K_LD,   16'h0080, 32'h0,        32'h0BADF00D, 5'd12, 1'b0, 1, 2, 32'h0BADF00D, 5'd12, 1'b1};
    vecs[5] = '{K_LDST, 16'h0020, 32'h11112222, 32'h33334444, 5'd5,  1'b1, 0, 0, 32'h00000000, 5'd5,  1'b0};
    vecs[6] = '{K_ST,   16'hFFFF, 32'h80000001, 32'h55555555, 5'd0,  1'b1, 0, 1, 32'h00000000, 5'd0,  1'b0};
    vecs[7] = '{K_LD,   16'h0000, 32'h0,        32'h00000000, 5'd31, 1'b0, 2, 0, 32'h00000000, 5'd31, 1'b1};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_v_o", 32'(v_o), 32'd0);
    chk("rst_wb_o", 32'(wb_o), 32'd0);
    chk("rst_mem_req_o", 32'(mem_req_o), 32'd0);
    chk("rst_stall_o", 32'(stall_o), 32'd0);
    chk("rst_result_o", result_o, 32'd0);
    chk("rst_mem_addr_o", 32'(mem_addr_o), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Table-driven vectors.
    foreach (vecs[k]) run_vec(vecs[k]);

    // Valid output holds under downstream stall, and the held instruction is
    // accepted once the stall drops.
    v_i = 1'b1; ld_i = 1'b0; st_i = 1'b0; result_i = 32'h00005A5A; wb_r_i = 5'd9; wb_i = 1'b1;
    sb.push_back('{32'h00005A5A, 5'd9, 1'b1});
    @(posedge clk); #1;
    stall_i = 1'b1; result_i = 32'h00000F0F; wb_r_i = 5'd10; wb_i = 1'b0;
    for (int s = 0; s < 2; s++) begin
      @(posedge clk); #1;
      chk("hold_v_o", 32'(v_o), 32'd1);
      chk("hold_result_o", result_o, 32'h00005A5A);
      chk("hold_wb_r_o", 32'(wb_r_o), 32'd9);
      chk("hold_stall_o", 32'(stall_o), 32'd1);
    end
    sb.push_back('{32'h00000F0F, 5'd10, 1'b0});
    stall_i = 1'b0;
    @(posedge clk); #1;
    v_i = 1'b0;
    chk("hold_release_result_o", result_o, 32'h00000F0F);

    // Back-to-back: an ALU op waiting behind a load lands exactly one cycle after it.
    v_i = 1'b1; ld_i = 1'b1; st_i = 1'b0; addr_i = 16'h0100; wb_r_i = 5'd9; wb_i = 1'b0;
    sb.push_back('{32'h00000077, 5'd9, 1'b1});
    @(posedge clk); #1;
    chk("b2b_mem_req_o", 32'(mem_req_o), 32'd1);
    chk("b2b_stall_o", 32'(stall_o), 32'd1);
    ld_i = 1'b0; result_i = 32'h00000055; wb_r_i = 5'd4; wb_i = 1'b1;
    sb.push_back('{32'h00000055, 5'd4, 1'b1});
    mem_ack_i = 1'b1; mem_rdata_i = 32'h00000077;
    @(posedge clk); #1;
    mem_ack_i = 1'b0; mem_rdata_i = 32'hFFFFFFFF;
    chk("b2b_load_result_o", result_o, 32'h00000077);
    chk("b2b_load_wb_r_o", 32'(wb_r_o), 32'd9);
    chk("b2b_stall_o_idle", 32'(stall_o), 32'd0);
    @(posedge clk); #1;
    v_i = 1'b0;
    chk("b2b_alu_v_o", 32'(v_o), 32'd1);
    chk("b2b_alu_result_o", result_o, 32'h00000055);
    chk("b2b_alu_wb_r_o", 32'(wb_r_o), 32'd4);

    // Ack pulse outside REQ must be ignored.
    @(posedge clk); #1;
    mem_ack_i = 1'b1; mem_rdata_i = 32'h12345678;
    @(posedge clk); #1;
    mem_ack_i = 1'b0;
    chk("stray_ack_mem_req_o", 32'(mem_req_o), 32'd0);
    chk("stray_ack_stall_o", 32'(stall_o), 32'd0);
    chk("stray_ack_v_o", 32'(v_o), 32'd0);

    // Reset in the middle of an access: outputs drop before the next clock edge.
    v_i = 1'b1; ld_i = 1'b1; st_i = 1'b0; addr_i = 16'h0200; wb_r_i = 5'd6; wb_i = 1'b0;
    @(posedge clk); #1;
    v_i = 1'b0; ld_i = 1'b0;
    chk("mid_mem_req_o", 32'(mem_req_o), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_mem_req_o", 32'(mem_req_o), 32'd0);
    chk("mid_rst_stall_o", 32'(stall_o), 32'd0);
    chk("mid_rst_v_o", 32'(v_o), 32'd0);
    chk("mid_rst_wb_o", 32'(wb_o), 32'd0);
    chk("mid_rst_mem_addr_o", 32'(mem_addr_o), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_stall_o", 32'(stall_o), 32'd0);
    run_vec(vecs[0]);
    run_vec(vecs[2]);

    @(posedge clk); #1;
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/memory_access_stage.md
Name: memory_access_stage

Overview:
- Pipeline stage directly downstream of the execute stage and upstream of register write-back.
- Consumes the execute stage's result, write-back tag and load/store request.
- Performs load/store accesses on the data-memory port using a req/ack handshake.
- Presents a registered result, destination register and write enable to write-back; back-pressures execute while an access is outstanding.

Parameters:
- ADDR, 16, address width of the data-memory port
- W_OPR, 32, operand/result/data width
- W_RD, 5, destination register index width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- v_i  in  1  input instruction valid (from execute v_o)
- ld_i  in  1  instruction is a load
- st_i  in  1  instruction is a store
- addr_i  in  ADDR  load/store address
- st_data_i  in  W_OPR  store data
- result_i  in  W_OPR  execute result (non-memory ops)
- wb_r_i  in  W_RD  destination register
- wb_i  in  1  write-back enable from execute
- stall_i  in  1  downstream stall
- stall_o  out  1  stall to execute stage
- mem_req_o  out  1  data-memory request
- mem_we_o  out  1  1 = write, 0 = read
- mem_addr_o  out  ADDR  memory address
- mem_wdata_o  out  W_OPR  memory write data
- mem_ack_i  in  1  memory completion, one-cycle pulse
- mem_rdata_i  in  W_OPR  read data, valid when mem_ack_i=1
- v_o  out  1  output valid to write-back
- result_o  out  W_OPR  value to write back
- wb_r_o  out  W_RD  destination register
- wb_o  out  1  register write enable

Behaviour:
- Clock and reset: one clock `clk`. `reset` is asynchronous and active-high. It forces state IDLE and clears every register, so all outputs read 0, including mem_req_o and stall_o.
- State machine: IDLE, REQ (access outstanding), DONE (access complete, downstream stalled).
- stall_o = stall_i | (state != IDLE). This is combinational.
- Memory op: mem op = v_i & (ld_i | st_i). st_i has priority if both ld_i and st_i are high.
- Accepting a memory op (IDLE, ~stall_i, mem op):
  - Capture addr, wdata, we=st_i, wb_r_i and the ld/st kind into request registers; go to REQ.
  - The output register loads a bubble: v_o=0, wb_o=0.
- Accepting a non-memory op (IDLE, ~stall_i, v_i, not a mem op):
  - Output register loads v_o=1, result_o=result_i, wb_r_o=wb_r_i, wb_o=wb_i.
  - Latency is 1 cycle.
- IDLE, ~stall_i, v_i=0: output register loads a bubble.
- REQ state:
  - mem_req_o=1; mem_addr_o, mem_we_o and mem_wdata_o come from the request registers and stay stable until ack.
  - mem_req_o is registered, so ack can arrive no earlier than the cycle after acceptance.
  - No ack and ~stall_i: output register loads a bubble.
- Ack in REQ with ~stall_i:
  - Output register loads v_o=1 and wb_r_o from the request registers.
  - Load: result_o=mem_rdata_i, wb_o=1.
  - Store: result_o=0, wb_o=0.
  - Go to IDLE. Minimum load/store latency is 2 cycles from acceptance.
- Ack in REQ with stall_i: latch mem_rdata_i into the hold register; go to DONE. mem_req_o drops the next cycle.
- DONE state: mem_req_o=0. When ~stall_i, load the output register from the hold/request registers exactly as on ack; go to IDLE.
- Output register under stall: whenever stall_i=1, all output-register fields hold their value. This holds in every state.
- Ordering: execute holds its instruction while stall_o=1. The next instruction is therefore accepted only in the IDLE cycle after completion, and memory ops complete in order.
- mem_ack_i outside REQ is ignored.
- Reset mid-access: mem_req_o drops immediately and the access is abandoned. The memory side must tolerate a withdrawn request.
- Width rule: no arithmetic in this stage; all data paths are passed through at full width.

Decomposition:
- Shared params include: ADDR, W_OPR and W_RD; state encodings IDLE=2'd0, REQ=2'd1, DONE=2'd2.
- One natural sub-module: mem_req_fsm. It holds the state register, request/hold registers and the mem_* outputs, and exports a done pulse and completed data.
- Output register and stall logic stay in the top module.

Test Plan:
- Pass-through: v_i=1, ld=st=0, result_i=32'h1234, wb_r_i=5'd3, wb_i=1, stall_i=0 -> next cycle v_o=1, result_o=32'h1234, wb_r_o=3, wb_o=1; stall_o=0 throughout.
- Load with 1-cycle ack: ld_i=1, addr_i=16'h0040, wb_r_i=5'd7 -> cycle+1: mem_req_o=1, mem_we_o=0, mem_addr_o=16'h0040, stall_o=1. Ack with mem_rdata_i=32'hDEADBEEF -> cycle+2: v_o=1, result_o=32'hDEADBEEF, wb_r_o=7, wb_o=1, stall_o=0.
- Store with 3-cycle wait: st_i=1, addr_i=16'h0010, st_data_i=32'hA5A5A5A5 -> mem_req_o=1 with we=1 and stable address/data for 3 cycles. v_o=0 during the wait. After ack: v_o=1, wb_o=0.
- Downstream stall at ack: load acked while stall_i=1 held 2 cycles -> state DONE, mem_req_o=0, outputs unchanged. After stall_i drops: v_o=1 with latched read data in the next cycle.
- Back-to-back: a load followed by an ALU op presented during REQ -> the ALU op is held by stall_o. Its output appears exactly 1 cycle after the load's output.
- Reset mid-access: assert reset while in REQ -> mem_req_o, v_o, wb_o and stall_o go to 0 immediately. After release, the stage is IDLE and accepts new instructions.
